// File: rtl/game_defs_pkg.sv
// Shared game definitions used by match_ctrl, the arms generators, the
// movement blocks and the renderer.
//   state_t   : 3-bit game state bus encoding
//   HP_FULL   : full HP value; anything above it is a wrapped HP and counts as KO
//   SCREEN_*  : screen geometry shared by the movement blocks and the renderer
//   sat_inc2  : saturating 2-bit increment for round scores
package game_defs;

    typedef enum logic [2:0] {
        MENU  = 3'b000,
        GAME  = 3'b001,
        P1WIN = 3'b010,
        P2WIN = 3'b011,
        TIE   = 3'b100,
        PIONT = 3'b101
    } state_t;

    localparam int HP_FULL  = 100;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int GROUND_Y = 400;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/sec_ticker.sv
// One-second tick generator.
//   clk, rst : clock, asynchronous active-low reset
//   en       : count enable; the prescaler sits at 0 while low
//   clr      : synchronous clear, wins over en
//   tick     : high for one cycle when the prescaler is at CLK_PER_SEC-1
module sec_ticker #(
    parameter int CLK_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] cnt;

    // gated by en so a CLK_PER_SEC of 1 cannot tick outside counting states
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || !en)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: MENU -> rounds (GAME / PIONT) -> P1WIN / P2WIN / TIE.
//   clk, rst   : clock, asynchronous active-low reset
//   key_start  : start/confirm key (level); acted on at its rising edge only
//   p1HP, p2HP : player HP from the arms generators, registered once here
//   state      : game state bus (game_defs::state_t encoding)
//   timerSec   : seconds left in the current round
//   p1Score    : rounds won by P1 (saturating)
//   p2Score    : rounds won by P2 (saturating)
//   roundNum   : current round 1..MAX_ROUNDS, 0 in MENU
module match_ctrl #(
    parameter int CLK_PER_SEC = 100000000,
    parameter int ROUND_SEC   = 60,
    parameter int HOLD_SEC    = 3,
    parameter int WIN_ROUNDS  = 2,
    parameter int MAX_ROUNDS  = 3,
    parameter int HP_FULL     = game_defs::HP_FULL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic [7:0] p1HP,
    input  logic [7:0] p2HP,
    output logic [2:0] state,
    output logic [6:0] timerSec,
    output logic [1:0] p1Score,
    output logic [1:0] p2Score,
    output logic [1:0] roundNum
);

    import game_defs::*;

    localparam logic [6:0] RSEC      = ROUND_SEC[6:0];
    localparam logic [7:0] HOLD_LAST = HOLD_SEC[7:0] - 8'd1;
    localparam logic [7:0] HP_MAX    = HP_FULL[7:0];
    localparam logic [1:0] WIN_V     = WIN_ROUNDS[1:0];
    localparam logic [1:0] MAX_V     = MAX_ROUNDS[1:0];

    state_t     st, st_nxt;
    logic [6:0] tmr, tmr_nxt;
    logic [1:0] s1, s1_nxt, s2, s2_nxt;
    logic [1:0] rnd, rnd_nxt;
    logic [7:0] hold, hold_nxt;
    logic       key_d;
    logic [7:0] hp1_q, hp2_q;
    logic       press, ko1, ko2, tick, tick_en;

    assign press   = key_start & ~key_d;
    assign ko1     = (hp1_q == 8'd0) || (hp1_q > HP_MAX);
    assign ko2     = (hp2_q == 8'd0) || (hp2_q > HP_MAX);
    assign tick_en = (st == GAME) || (st == PIONT);

    // prescaler restarts on every state change so each round and each
    // hold period starts on a full second
    sec_ticker #(.CLK_PER_SEC(CLK_PER_SEC)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (st_nxt != st),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= MENU;
            tmr   <= RSEC;
            s1    <= 2'd0;
            s2    <= 2'd0;
            rnd   <= 2'd0;
            hold  <= 8'd0;
            key_d <= 1'b0;
            hp1_q <= HP_MAX;
            hp2_q <= HP_MAX;
        end else begin
            st    <= st_nxt;
            tmr   <= tmr_nxt;
            s1    <= s1_nxt;
            s2    <= s2_nxt;
            rnd   <= rnd_nxt;
            hold  <= hold_nxt;
            key_d <= key_start;
            hp1_q <= p1HP;
            hp2_q <= p2HP;
        end
    end

    always_comb begin
        st_nxt   = st;
        tmr_nxt  = tmr;
        s1_nxt   = s1;
        s2_nxt   = s2;
        rnd_nxt  = rnd;
        hold_nxt = hold;
        case (st)
            MENU: begin
                if (press) begin
                    st_nxt  = GAME;
                    rnd_nxt = 2'd1;
                    s1_nxt  = 2'd0;
                    s2_nxt  = 2'd0;
                    tmr_nxt = RSEC;
                end
            end
            GAME: begin
                // keeping hold at 0 here means PIONT always starts from 0
                hold_nxt = 8'd0;
                if (ko1 || ko2) begin
                    st_nxt = PIONT;
                    if (ko2 && !ko1)
                        s1_nxt = sat_inc2(s1);
                    else if (ko1 && !ko2)
                        s2_nxt = sat_inc2(s2);
                end else if (tick && tmr == 7'd1) begin
                    st_nxt  = PIONT;
                    tmr_nxt = 7'd0;
                    if (hp1_q > hp2_q)
                        s1_nxt = sat_inc2(s1);
                    else if (hp2_q > hp1_q)
                        s2_nxt = sat_inc2(s2);
                end else if (tick && tmr != 7'd0) begin
                    tmr_nxt = tmr - 7'd1;
                end
            end
            PIONT: begin
                if (tick) begin
                    if (hold == HOLD_LAST) begin
                        hold_nxt = 8'd0;
                        if (s1 == WIN_V)
                            st_nxt = P1WIN;
                        else if (s2 == WIN_V)
                            st_nxt = P2WIN;
                        else if (rnd == MAX_V)
                            st_nxt = (s1 > s2) ? P1WIN : (s2 > s1) ? P2WIN : TIE;
                        else begin
                            st_nxt  = GAME;
                            rnd_nxt = rnd + 2'd1;
                            tmr_nxt = RSEC;
                        end
                    end else begin
                        hold_nxt = hold + 8'd1;
                    end
                end
            end
            P1WIN, P2WIN, TIE: begin
                // scores stay on screen until the next match starts
                if (press) begin
                    st_nxt  = MENU;
                    rnd_nxt = 2'd0;
                    tmr_nxt = RSEC;
                end
            end
            default: st_nxt = MENU;
        endcase
    end

    assign state    = st;
    assign timerSec = tmr;
    assign p1Score  = s1;
    assign p2Score  = s2;
    assign roundNum = rnd;

endmodule

// File: tb/tb_match_ctrl.sv
module tb_match_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_start;
    logic [7:0] p1HP, p2HP;
    logic [2:0] state;
    logic [6:0] timerSec;
    logic [1:0] p1Score, p2Score, roundNum;

    int n_chk  = 0;
    int n_fail = 0;

    match_ctrl #(
        .CLK_PER_SEC(4), .ROUND_SEC(5), .HOLD_SEC(2),
        .WIN_ROUNDS(2), .MAX_ROUNDS(3), .HP_FULL(100)
    ) dut (
        .clk(clk), .rst(rst), .key_start(key_start),
        .p1HP(p1HP), .p2HP(p2HP),
        .state(state), .timerSec(timerSec),
        .p1Score(p1Score), .p2Score(p2Score), .roundNum(roundNum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // full snapshot: state, round, timer, scores
    task automatic snap(input string tag, input int st, input int rn, input int tm,
                        input int a, input int b);
        chk({tag, ".state"}, {29'd0, state}, st);
        chk({tag, ".round"}, {30'd0, roundNum}, rn);
        chk({tag, ".timer"}, {25'd0, timerSec}, tm);
        chk({tag, ".p1s"}, {30'd0, p1Score}, a);
        chk({tag, ".p2s"}, {30'd0, p2Score}, b);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // clean rising edge on key_start, returns just after the edge that sees it
    task automatic press();
        key_start = 1'b0;
        step(1);
        key_start = 1'b1;
        step(1);
        key_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; key_start = 1'b0; p1HP = 8'd100; p2HP = 8'd100;
        #12;
        snap("reset", 0, 0, 5, 0, 0);
        rst = 1'b1;
        step(1);

        // match A: key start, held key, two p2 KOs -> P1WIN
        key_start = 1'b1;
        step(1);
        snap("a_start", 1, 1, 5, 0, 0);
        step(3);
        chk("a_held_key", {29'd0, state}, 1);
        key_start = 1'b0;
        p2HP = 8'd0;
        step(1);
        chk("a_hp_latency", {29'd0, state}, 1);
        step(1);
        snap("a_r1_ko", 5, 1, 4, 1, 0);
        p2HP = 8'd100;
        step(7);
        chk("a_hold_end", {29'd0, state}, 5);
        step(1);
        snap("a_r2", 1, 2, 5, 1, 0);
        p2HP = 8'd0;
        step(2);
        snap("a_r2_ko", 5, 2, 5, 2, 0);
        p2HP = 8'd100;
        step(8);
        chk("a_p1win", {29'd0, state}, 2);
        key_start = 1'b1;
        step(1);
        snap("a_menu", 0, 0, 5, 2, 0);
        step(5);
        chk("a_menu_held", {29'd0, state}, 0);
        key_start = 1'b0;

        // match B: timeouts, HP 70/40 then 50/50, round-3 draw -> P1WIN on score
        p1HP = 8'd70; p2HP = 8'd40;
        press();
        snap("b_start", 1, 1, 5, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(4);
            chk($sformatf("b_timer_%0d", k), {25'd0, timerSec}, 5 - k);
        end
        step(3);
        snap("b_last_sec", 1, 1, 1, 0, 0);
        step(1);
        snap("b_r1_timeout", 5, 1, 0, 1, 0);
        p1HP = 8'd50; p2HP = 8'd50;
        step(8);
        snap("b_r2", 1, 2, 5, 1, 0);
        step(19);
        chk("b_r2_last", {25'd0, timerSec}, 1);
        step(1);
        snap("b_r2_draw", 5, 2, 0, 1, 0);
        step(8);
        snap("b_r3", 1, 3, 5, 1, 0);
        p1HP = 8'd0; p2HP = 8'd0;
        step(2);
        snap("b_r3_dbl_ko", 5, 3, 5, 1, 0);
        p1HP = 8'd100; p2HP = 8'd100;
        step(8);
        snap("b_p1win_score", 2, 3, 5, 1, 0);
        press();
        chk("b_menu", {29'd0, state}, 0);

        // match C: wrapped HP KO, p2 KO, round-3 double KO at 1-1 -> TIE
        press();
        snap("c_start", 1, 1, 5, 0, 0);
        p1HP = 8'd246;
        step(1);
        chk("c_wrap_latency", {29'd0, state}, 1);
        step(1);
        snap("c_wrap_ko", 5, 1, 5, 0, 1);
        p1HP = 8'd100;
        step(8);
        chk("c_r2", {30'd0, roundNum}, 2);
        p2HP = 8'd0;
        step(2);
        snap("c_r2_ko", 5, 2, 5, 1, 1);
        p2HP = 8'd100;
        step(8);
        snap("c_r3", 1, 3, 5, 1, 1);
        p1HP = 8'd0; p2HP = 8'd0;
        step(2);
        snap("c_r3_dbl_ko", 5, 3, 5, 1, 1);
        p1HP = 8'd100; p2HP = 8'd100;
        step(7);
        chk("c_hold_end", {29'd0, state}, 5);
        step(1);
        snap("c_tie", 4, 3, 5, 1, 1);
        press();
        snap("c_menu", 0, 0, 5, 1, 1);

        // match D: asynchronous reset mid-round, away from any clock edge
        press();
        p2HP = 8'd0;
        step(2);
        chk("d_ko", {30'd0, p1Score}, 1);
        p2HP = 8'd100;
        step(8);
        chk("d_r2", {29'd0, state}, 1);
        step(1);
        #3;
        rst = 1'b0;
        #1;
        snap("d_async_rst", 0, 0, 5, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
Top-level match sequencer. It sits downstream of the per-player arms generators: it consumes their p1HP/p2HP outputs and produces the 3-bit game `state` bus that those generators, the movement blocks and the renderer all decode. It runs MENU → rounds (GAME/PIONT) → P1WIN/P2WIN/TIE, and maintains a per-round countdown, round number and round scores.

Parameters:
CLK_PER_SEC, 100000000, clk cycles per one-second tick
ROUND_SEC, 60, round length in seconds (≤127)
HOLD_SEC, 3, seconds spent in PIONT between rounds
WIN_ROUNDS, 2, round wins needed to take the match
MAX_ROUNDS, 3, maximum rounds per match (≤3)
HP_FULL, 100, full HP value; any HP above this is treated as wrapped/KO

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-low (rst=0 resets)
key_start  in  1  start/confirm key, level, synchronous to clk
p1HP  in  8  player-1 HP, from P2 arms generator
p2HP  in  8  player-2 HP, from P1 arms generator
state  out  3  MENU=000 GAME=001 P1WIN=010 P2WIN=011 TIE=100 PIONT=101
timerSec  out  7  seconds left in the current round
p1Score  out  2  rounds won by P1
p2Score  out  2  rounds won by P2
roundNum  out  2  current round, 1..MAX_ROUNDS; 0 in MENU

Behaviour:
- Reset (rst=0, async): state=MENU, timerSec=ROUND_SEC, scores=0, roundNum=0, prescaler=0, key history=0, HP registers=HP_FULL.
- press = key_start & ~key_start_d (one-cycle rising edge). A held key never repeats.
- p1HP/p2HP are registered once (hp_q). All decisions use hp_q, giving 1-cycle latency.
- KO_x = (hpx_q == 0) || (hpx_q > HP_FULL).
- tick = prescaler == CLK_PER_SEC-1.
  - The prescaler wraps to 0 on tick.
  - It is cleared on every state change.
  - It counts only in GAME and PIONT, and holds 0 elsewhere.
- MENU: on press → GAME. On that edge: roundNum=1, scores=0, timerSec=ROUND_SEC.
- GAME, evaluated each cycle in this priority order:
  1. KO_1 || KO_2 → PIONT.
     - Both KO: draw, no score change.
     - Only p2 KO: p1Score+1.
     - Only p1 KO: p2Score+1.
  2. Otherwise, tick && timerSec==1 → timerSec=0, then → PIONT. Higher hp_q scores +1; equal HP is a draw.
  3. Otherwise, tick → timerSec-1.
  - Scores are updated on the same edge as the GAME→PIONT transition.
  - press is ignored in GAME.
- PIONT:
  - A hold counter is cleared on entry and increments on each tick.
  - When it reaches HOLD_SEC, the next state is chosen in this order:
    1. p1Score==WIN_ROUNDS → P1WIN.
    2. p2Score==WIN_ROUNDS → P2WIN.
    3. roundNum==MAX_ROUNDS → larger score wins; equal scores → TIE.
    4. Otherwise, roundNum+1, timerSec=ROUND_SEC → GAME.
- P1WIN/P2WIN/TIE: outputs frozen. On press → MENU, with roundNum=0 and timerSec=ROUND_SEC. Scores stay visible until the next MENU→GAME.
- Unused encodings 110/111 → MENU on the next edge.
- Scores saturate at 3. Score arithmetic is 2-bit, timer arithmetic 7-bit; neither may wrap.
- Reset asserted mid-round: immediate MENU with reset values. No partial round is recorded.
- The HP generators reset HP to HP_FULL in every non-GAME state. HP_FULL therefore appears in hp_q well before GAME re-entry. No KO masking on entry is required.

Decomposition:
- Shared package game_defs: state encodings MENU/GAME/P1WIN/P2WIN/TIE/PIONT (3-bit), HP_FULL, and screen constants already used by the arms/movement blocks.
- One sub-module, sec_ticker:
  - Parameter CLK_PER_SEC.
  - Inputs: clk, rst, en, clr. Output: tick.
  - Instantiated once; match_ctrl drives clr on every state change.

Test Plan (CLK_PER_SEC=4, ROUND_SEC=5, HOLD_SEC=2, WIN_ROUNDS=2, MAX_ROUNDS=3):
1. Reset, HP=100/100, press key → state=001 after 1 edge, roundNum=1, timerSec=5. Holding the key for 50 cycles causes no further transition.
2. In GAME, drive p2HP=0 → 2 edges later state=101, p1Score=1. After 8 cycles → state=001, roundNum=2, timerSec=5.
3. Repeat the p2 KO in round 2 → PIONT, p1Score=2. After 8 cycles → state=010. press → state=000, roundNum=0.
4. Timeout: HP=70/40 for the whole round → timerSec steps 5→0 every 4 cycles, then state=101 with p1Score+1. A repeat with HP=50/50 → no score change.
5. Both KO simultaneously in round 3 with scores 1–1 → draw. After hold, roundNum==3 with equal scores → state=100 (TIE).
6. p1HP=246 (wrapped) → treated as KO, p2Score+1. Assert rst=0 mid-GAME with no clock → state=000 and scores=0 immediately.
